// File: rtl/card_driver_ctrl_if.sv
// ---------------------------------------------------------------------------
// card_driver_ctrl_if
//   Bundles the response handshake and the SPI card pins of card_driver_ctrl.
//
//   res_stb  : response byte valid (driver -> consumer)
//   res_data : response byte, 8 bits (driver -> consumer)
//   res_ack  : consumer accepts res_data (consumer -> driver)
//   mosi     : SPI data to card
//   miso     : SPI data from card
//   sclk     : SPI clock, idle low (mode 0)
//   cs       : card select, active low
//
//   master : the card driver side
//   slave  : the consumer / card side (used by the testbench)
// ---------------------------------------------------------------------------
interface card_driver_ctrl_if;
  logic       res_stb;
  logic [7:0] res_data;
  logic       res_ack;
  logic       mosi;
  logic       miso;
  logic       sclk;
  logic       cs;

  modport master (
    output res_stb, res_data, mosi, sclk, cs,
    input  res_ack, miso
  );

  modport slave (
    input  res_stb, res_data, mosi, sclk, cs,
    output res_ack, miso
  );
endinterface

// File: rtl/card_driver_ctrl.sv
// ---------------------------------------------------------------------------
// card_driver_ctrl
//   SD card SPI bring-up sequencer. After reset it sends INIT_CLOCKS SCLK
//   pulses with CS high, then issues CMD0, polls for the R1 response and
//   hands it to a consumer over a strobe/ack handshake. With the macro
//   CARD_DRIVER_CMD8_EN defined it continues with CMD8 and presents the
//   five-byte R7 response (R1 + four trailing bytes). Without the macro the
//   CMD8 stage is not built and the sequencer stops after the CMD0 response.
//
// Parameters
//   CLK_DIV     : clk cycles per SCLK half-period (>= 1)
//   INIT_CLOCKS : SCLK pulses sent with CS high after reset
//   POLL_LIMIT  : maximum 0xFF poll bytes while waiting for R1
//
// Ports
//   clk       : system clock, rising edge
//   rst       : asynchronous reset, active low
//   bus       : card_driver_ctrl_if.master (response handshake + SPI pins)
//   dbg_state : current FSM state encoding (see state_t)
//
// Configuration macro: CARD_DRIVER_CMD8_EN
// ---------------------------------------------------------------------------
module card_driver_ctrl #(
  parameter int CLK_DIV     = 2,
  parameter int INIT_CLOCKS = 80,
  parameter int POLL_LIMIT  = 8
) (
  input  logic               clk,
  input  logic               rst,
  card_driver_ctrl_if.master bus,
  output logic [2:0]         dbg_state
);

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int INIT_W = $clog2(INIT_CLOCKS + 1);
  localparam int POLL_W = $clog2(POLL_LIMIT + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CLOCKS - 1);
  localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_LIMIT - 1);
  localparam logic [2:0]        CMD_LAST  = 3'd5;

  typedef enum logic [2:0] {
    ST_INIT      = 3'd0,
    ST_CMD0_TX   = 3'd1,
    ST_CMD0_POLL = 3'd2,
    ST_CMD0_RES  = 3'd3,
    ST_CMD8_TX   = 3'd4,
    ST_CMD8_POLL = 3'd5,
    ST_CMD8_RES  = 3'd6,
    ST_DONE      = 3'd7
  } state_t;

  function automatic logic [7:0] cmd0_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    cmd0_byte = 8'h40;
      3'd5:    cmd0_byte = 8'h95;
      default: cmd0_byte = 8'h00;
    endcase
  endfunction

`ifdef CARD_DRIVER_CMD8_EN
  function automatic logic [7:0] cmd8_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    cmd8_byte = 8'h48;
      3'd3:    cmd8_byte = 8'h01;
      3'd4:    cmd8_byte = 8'hAA;
      3'd5:    cmd8_byte = 8'h87;
      default: cmd8_byte = 8'h00;
    endcase
  endfunction
`endif

  state_t              state, state_next;
  logic [DIV_W-1:0]    div_cnt;
  logic                sclk_q;
  logic [2:0]          bit_cnt;
  logic [2:0]          byte_cnt;
  logic [POLL_W-1:0]   poll_cnt;
  logic [INIT_W-1:0]   init_cnt;
  logic [7:0]          tx_sr;
  logic [7:0]          rx_sr;
  logic                res_stb_q;
  logic [7:0]          res_data_q;
`ifdef CARD_DRIVER_CMD8_EN
  logic                timeout_q;
`endif

  logic       run;
  logic       tick;
  logic       rise;
  logic       fall;
  logic       byte_done;
  logic       init_done;
  logic       poll_last;
  logic       accept;
  logic [7:0] next_cmd;

  // The SCLK generator only runs while a state is actually moving bits.
  // A pending response (res_stb high) stops it, which freezes SCLK low
  // because every byte completes on a falling edge.
  always_comb begin
    run = 1'b0;
    case (state)
      ST_INIT, ST_CMD0_TX, ST_CMD0_POLL: run = 1'b1;
`ifdef CARD_DRIVER_CMD8_EN
      ST_CMD8_TX, ST_CMD8_POLL:          run = 1'b1;
      ST_CMD8_RES:                       run = ~res_stb_q;
`endif
      default:                           run = 1'b0;
    endcase
  end

  assign tick      = run && (div_cnt == DIV_LAST);
  assign rise      = tick && !sclk_q;
  assign fall      = tick && sclk_q;
  assign byte_done = fall && (bit_cnt == 3'd7);
  assign init_done = fall && (init_cnt == INIT_LAST);
  assign poll_last = (poll_cnt == POLL_LAST);

  // Handshake: the driver raises res_stb with res_data and holds both
  // stable; a transfer happens on any clk edge where res_stb and res_ack are
  // both high, and res_stb falls on that same edge. res_ack is ignored while
  // res_stb is low.
  assign accept = res_stb_q && bus.res_ack;

  always_comb begin
    next_cmd = cmd0_byte(3'(byte_cnt + 3'd1));
`ifdef CARD_DRIVER_CMD8_EN
    if (state == ST_CMD8_TX) next_cmd = cmd8_byte(3'(byte_cnt + 3'd1));
`endif
  end

  // ---------------------------------------------------------------- FSM: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_INIT;
    else      state <= state_next;
  end

  // ---------------------------------------------------------------- FSM: next state
  always_comb begin
    state_next = state;
    case (state)
      ST_INIT:      if (init_done) state_next = ST_CMD0_TX;
      ST_CMD0_TX:   if (byte_done && byte_cnt == CMD_LAST) state_next = ST_CMD0_POLL;
      ST_CMD0_POLL: if (byte_done && (!rx_sr[7] || poll_last)) state_next = ST_CMD0_RES;
      ST_CMD0_RES: begin
        if (accept) begin
`ifdef CARD_DRIVER_CMD8_EN
          state_next = timeout_q ? ST_DONE : ST_CMD8_TX;
`else
          state_next = ST_DONE;
`endif
        end
      end
`ifdef CARD_DRIVER_CMD8_EN
      ST_CMD8_TX:   if (byte_done && byte_cnt == CMD_LAST) state_next = ST_CMD8_POLL;
      ST_CMD8_POLL: if (byte_done && (!rx_sr[7] || poll_last)) state_next = ST_CMD8_RES;
      ST_CMD8_RES:  if (accept && (timeout_q || byte_cnt == 3'd4)) state_next = ST_DONE;
`endif
      ST_DONE:      state_next = ST_DONE;
      default:      state_next = ST_INIT;
    endcase
  end

  // ---------------------------------------------------------------- FSM: outputs
  always_comb begin
    bus.cs   = 1'b1;
    bus.mosi = 1'b1;
    case (state)
      ST_INIT, ST_DONE: begin
        bus.cs   = 1'b1;
        bus.mosi = 1'b1;
      end
      default: begin
        bus.cs   = 1'b0;
        bus.mosi = tx_sr[7];
      end
    endcase
    bus.sclk     = sclk_q;
    bus.res_stb  = res_stb_q;
    bus.res_data = res_data_q;
    dbg_state    = state;
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt    <= '0;
      sclk_q     <= 1'b0;
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      poll_cnt   <= '0;
      init_cnt   <= '0;
      tx_sr      <= 8'hFF;
      rx_sr      <= '0;
      res_stb_q  <= 1'b0;
      res_data_q <= '0;
`ifdef CARD_DRIVER_CMD8_EN
      timeout_q  <= 1'b0;
`endif
    end else begin
      if (!run) begin
        div_cnt <= '0;
        sclk_q  <= 1'b0;
      end else if (tick) begin
        div_cnt <= '0;
        sclk_q  <= ~sclk_q;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end

      if (rise) rx_sr <= {rx_sr[6:0], bus.miso};

      // MOSI is tx_sr[7]; shifting only on falls keeps it stable around
      // each rising edge. Loads below override the shift on byte boundaries.
      if (fall) begin
        bit_cnt <= bit_cnt + 3'd1;
        tx_sr   <= {tx_sr[6:0], 1'b1};
      end

      case (state)
        ST_INIT: begin
          if (fall) init_cnt <= init_cnt + INIT_W'(1);
          if (init_done) begin
            bit_cnt  <= '0;
            byte_cnt <= '0;
            tx_sr    <= cmd0_byte(3'd0);
          end
        end

`ifdef CARD_DRIVER_CMD8_EN
        ST_CMD0_TX, ST_CMD8_TX: begin
`else
        ST_CMD0_TX: begin
`endif
          if (byte_done) begin
            if (byte_cnt == CMD_LAST) begin
              byte_cnt <= '0;
              poll_cnt <= '0;
              tx_sr    <= 8'hFF;
            end else begin
              byte_cnt <= byte_cnt + 3'd1;
              tx_sr    <= next_cmd;
            end
          end
        end

`ifdef CARD_DRIVER_CMD8_EN
        ST_CMD0_POLL, ST_CMD8_POLL: begin
`else
        ST_CMD0_POLL: begin
`endif
          if (byte_done) begin
            poll_cnt <= poll_cnt + POLL_W'(1);
            tx_sr    <= 8'hFF;
            if (!rx_sr[7]) begin
              res_stb_q  <= 1'b1;
              res_data_q <= rx_sr;
`ifdef CARD_DRIVER_CMD8_EN
              timeout_q  <= 1'b0;
`endif
            end else if (poll_last) begin
              // No R1 within the poll window: report 0xFF once, then stop.
              res_stb_q  <= 1'b1;
              res_data_q <= 8'hFF;
`ifdef CARD_DRIVER_CMD8_EN
              timeout_q  <= 1'b1;
`endif
            end
          end
        end

        ST_CMD0_RES: begin
          if (accept) begin
            res_stb_q <= 1'b0;
`ifdef CARD_DRIVER_CMD8_EN
            tx_sr     <= cmd8_byte(3'd0);
            byte_cnt  <= '0;
`endif
          end
        end

`ifdef CARD_DRIVER_CMD8_EN
        // byte_cnt counts the trailing R7 bytes already presented.
        ST_CMD8_RES: begin
          if (accept) begin
            res_stb_q <= 1'b0;
            tx_sr     <= 8'hFF;
          end
          if (byte_done) begin
            res_stb_q  <= 1'b1;
            res_data_q <= rx_sr;
            byte_cnt   <= byte_cnt + 3'd1;
          end
        end
`endif

        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_card_driver_ctrl.sv
// ---------------------------------------------------------------------------
// tb_card_driver_ctrl
//   Directed bench for card_driver_ctrl. A byte-table card model drives
//   MISO (one new bit after every SCLK rise while CS is low), monitors count
//   INIT pulses, collect MOSI bytes and accepted response strobes, and each
//   test task compares them with hand-computed values.
//   Follows the DUT build: define CARD_DRIVER_CMD8_EN for both or neither.
// ---------------------------------------------------------------------------
module tb_card_driver_ctrl;
  localparam int CLK_DIV     = 2;
  localparam int INIT_CLOCKS = 80;
  localparam int POLL_LIMIT  = 8;
  localparam int BUDGET      = 4000;

  // ------------------------------------------------------------ clock / reset
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  card_driver_ctrl_if bus_if ();

  card_driver_ctrl #(
    .CLK_DIV    (CLK_DIV),
    .INIT_CLOCKS(INIT_CLOCKS),
    .POLL_LIMIT (POLL_LIMIT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus_if),
    .dbg_state(dbg_state)
  );

  int checks = 0;
  int passes = 0;

  // ------------------------------------------------------------ card model
  logic [7:0] card_bytes [0:63];
  int         gidx = 0;
  logic [7:0] cur_byte;

  always @(posedge bus_if.sclk or posedge bus_if.cs) begin
    if (bus_if.cs) gidx <= 0;
    else           gidx <= gidx + 1;
  end

  always_comb begin
    cur_byte = 8'hFF;
    if ((gidx / 8) < 64) cur_byte = card_bytes[gidx / 8];
  end

  assign bus_if.miso = cur_byte[7 - (gidx % 8)];

  // ------------------------------------------------------------ monitors
  int         init_rises     = 0;
  int         init_mosi_bad  = 0;
  int         mosi_bits      = 0;
  logic [7:0] mosi_sr        = 8'h00;
  logic [7:0] mosi_q[$];
  logic [7:0] obs_q[$];
  logic [7:0] exp_q[$];

  always @(posedge bus_if.sclk or negedge rst) begin
    if (!rst) begin
      init_rises    = 0;
      init_mosi_bad = 0;
      mosi_bits     = 0;
      mosi_q.delete();
    end else if (bus_if.cs) begin
      init_rises++;
      if (bus_if.mosi !== 1'b1) init_mosi_bad++;
    end else begin
      mosi_sr = {mosi_sr[6:0], bus_if.mosi};
      mosi_bits++;
      if (mosi_bits == 8) begin
        mosi_q.push_back(mosi_sr);
        mosi_bits = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) obs_q.delete();
    else if (bus_if.res_stb && bus_if.res_ack) obs_q.push_back(bus_if.res_data);
  end

  // ------------------------------------------------------------ driver tasks
  task automatic load_card_all_ff();
    for (int i = 0; i < 64; i++) card_bytes[i] = 8'hFF;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_state(input logic [2:0] s, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge clk);
      if (dbg_state == s) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // ------------------------------------------------------------ tests
  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus_if.cs !== 1'b1) $display("FAIL reset_cs: got %b expected 1", bus_if.cs); else passes++;
    checks++; if (bus_if.sclk !== 1'b0) $display("FAIL reset_sclk: got %b expected 0", bus_if.sclk); else passes++;
    checks++; if (bus_if.mosi !== 1'b1) $display("FAIL reset_mosi: got %b expected 1", bus_if.mosi); else passes++;
    checks++; if (bus_if.res_stb !== 1'b0) $display("FAIL reset_stb: got %b expected 0", bus_if.res_stb); else passes++;
    checks++; if (bus_if.res_data !== 8'h00) $display("FAIL reset_data: got %02h expected 00", bus_if.res_data); else passes++;
    checks++; if (dbg_state !== 3'd0) $display("FAIL reset_state: got %0d expected 0", dbg_state); else passes++;
  endtask

  task automatic test_init_cmd0();
    bit         ok;
    logic [7:0] exp_cmd [6];
    exp_cmd = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95};
    load_card_all_ff();
    bus_if.res_ack = 1'b1;
    do_reset();
    wait_state(3'd1, ok);
    checks++; if (ok !== 1'b1) $display("FAIL init_reach_cmd0: got %b expected 1", ok); else passes++;
    checks++; if (init_rises != INIT_CLOCKS) $display("FAIL init_pulses: got %0d expected %0d", init_rises, INIT_CLOCKS); else passes++;
    checks++; if (init_mosi_bad != 0) $display("FAIL init_mosi_high: got %0d low samples expected 0", init_mosi_bad); else passes++;
    wait_state(3'd2, ok);
    checks++; if (ok !== 1'b1) $display("FAIL cmd0_reach_poll: got %b expected 1", ok); else passes++;
    checks++; if (mosi_q.size() != 6) $display("FAIL cmd0_len: got %0d expected 6", mosi_q.size()); else passes++;
    for (int i = 0; i < 6 && i < mosi_q.size(); i++) begin
      checks++;
      if (mosi_q[i] !== exp_cmd[i]) $display("FAIL cmd0_byte[%0d]: got %02h expected %02h", i, mosi_q[i], exp_cmd[i]);
      else passes++;
    end
    checks++; if (bus_if.cs !== 1'b0) $display("FAIL cmd0_cs_low: got %b expected 0", bus_if.cs); else passes++;
  endtask

  task automatic test_mid_reset();
    bit ok;
    load_card_all_ff();
    bus_if.res_ack = 1'b1;
    do_reset();
    wait_state(3'd1, ok);
    checks++; if (ok !== 1'b1) $display("FAIL midrst_reach_cmd0: got %b expected 1", ok); else passes++;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (bus_if.cs !== 1'b1) $display("FAIL midrst_cs: got %b expected 1", bus_if.cs); else passes++;
    checks++; if (bus_if.sclk !== 1'b0) $display("FAIL midrst_sclk: got %b expected 0", bus_if.sclk); else passes++;
    checks++; if (bus_if.mosi !== 1'b1) $display("FAIL midrst_mosi: got %b expected 1", bus_if.mosi); else passes++;
    checks++; if (dbg_state !== 3'd0) $display("FAIL midrst_state: got %0d expected 0", dbg_state); else passes++;
    @(negedge clk);
    rst = 1'b1;
    wait_state(3'd1, ok);
    checks++; if (ok !== 1'b1) $display("FAIL midrst_restart: got %b expected 1", ok); else passes++;
    checks++; if (init_rises != INIT_CLOCKS) $display("FAIL midrst_pulses: got %0d expected %0d", init_rises, INIT_CLOCKS); else passes++;
  endtask

  task automatic test_r1();
    bit ok;
    load_card_all_ff();
    card_bytes[7] = 8'h87;
    card_bytes[8] = 8'h07;
    exp_q.delete();
    exp_q.push_back(8'h07);
`ifdef CARD_DRIVER_CMD8_EN
    exp_q.push_back(8'hFF);
`endif
    bus_if.res_ack = 1'b1;
    do_reset();
    wait_state(3'd7, ok);
    checks++; if (ok !== 1'b1) $display("FAIL r1_reach_done: got %b expected 1", ok); else passes++;
    checks++; if (obs_q.size() != exp_q.size()) $display("FAIL r1_strobes: got %0d expected %0d", obs_q.size(), exp_q.size()); else passes++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL r1_data[%0d]: got %02h expected %02h", i, obs_q[i], exp_q[i]);
      else passes++;
    end
    for (int i = 6; i < 9 && i < mosi_q.size(); i++) begin
      checks++;
      if (mosi_q[i] !== 8'hFF) $display("FAIL r1_poll_mosi[%0d]: got %02h expected ff", i, mosi_q[i]);
      else passes++;
    end
`ifdef CARD_DRIVER_CMD8_EN
    checks++; if (mosi_q.size() != 23) $display("FAIL r1_mosi_len: got %0d expected 23", mosi_q.size()); else passes++;
`else
    checks++; if (mosi_q.size() != 9) $display("FAIL r1_mosi_len: got %0d expected 9", mosi_q.size()); else passes++;
`endif
    checks++; if (bus_if.cs !== 1'b1) $display("FAIL r1_done_cs: got %b expected 1", bus_if.cs); else passes++;
  endtask

  task automatic test_timeout();
    bit         ok;
    logic [7:0] first;
    load_card_all_ff();
    bus_if.res_ack = 1'b1;
    do_reset();
    wait_state(3'd7, ok);
    checks++; if (ok !== 1'b1) $display("FAIL to_reach_done: got %b expected 1", ok); else passes++;
    repeat (40) @(negedge clk);
    first = (obs_q.size() > 0) ? obs_q[0] : 8'h00;
    checks++; if (obs_q.size() != 1) $display("FAIL to_strobes: got %0d expected 1", obs_q.size()); else passes++;
    checks++; if (first !== 8'hFF) $display("FAIL to_data: got %02h expected ff", first); else passes++;
    checks++; if (mosi_q.size() != 14) $display("FAIL to_bytes: got %0d expected 14", mosi_q.size()); else passes++;
    checks++; if (dbg_state !== 3'd7) $display("FAIL to_stay_done: got %0d expected 7", dbg_state); else passes++;
    checks++; if (bus_if.cs !== 1'b1) $display("FAIL to_cs: got %b expected 1", bus_if.cs); else passes++;
    checks++; if (bus_if.sclk !== 1'b0) $display("FAIL to_sclk: got %b expected 0", bus_if.sclk); else passes++;
    checks++; if (bus_if.mosi !== 1'b1) $display("FAIL to_mosi: got %b expected 1", bus_if.mosi); else passes++;
    checks++; if (bus_if.res_stb !== 1'b0) $display("FAIL to_stb: got %b expected 0", bus_if.res_stb); else passes++;
  endtask

  task automatic test_backpressure();
    bit ok;
    int bad;
    load_card_all_ff();
    card_bytes[6] = 8'h05;
    bus_if.res_ack = 1'b0;
    do_reset();
    wait_state(3'd3, ok);
    checks++; if (ok !== 1'b1) $display("FAIL bp_reach_res: got %b expected 1", ok); else passes++;
    checks++; if (bus_if.res_data !== 8'h05) $display("FAIL bp_data: got %02h expected 05", bus_if.res_data); else passes++;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus_if.res_stb !== 1'b1 || bus_if.res_data !== 8'h05 || bus_if.sclk !== 1'b0) bad++;
    end
    checks++; if (bad != 0) $display("FAIL bp_hold: got %0d bad cycles expected 0", bad); else passes++;
    #1 bus_if.res_ack = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (bus_if.res_stb !== 1'b0) $display("FAIL bp_stb_drop: got %b expected 0", bus_if.res_stb); else passes++;
`ifdef CARD_DRIVER_CMD8_EN
    checks++; if (dbg_state !== 3'd4) $display("FAIL bp_next_state: got %0d expected 4", dbg_state); else passes++;
`else
    checks++; if (dbg_state !== 3'd7) $display("FAIL bp_next_state: got %0d expected 7", dbg_state); else passes++;
`endif
    wait_state(3'd7, ok);
    checks++; if (ok !== 1'b1) $display("FAIL bp_reach_done: got %b expected 1", ok); else passes++;
  endtask

`ifdef CARD_DRIVER_CMD8_EN
  task automatic test_cmd8();
    bit         ok;
    logic [7:0] exp_cmd [6];
    exp_cmd = '{8'h48, 8'h00, 8'h00, 8'h01, 8'hAA, 8'h87};
    load_card_all_ff();
    card_bytes[6]  = 8'h01;
    card_bytes[13] = 8'h01;
    card_bytes[14] = 8'h00;
    card_bytes[15] = 8'h00;
    card_bytes[16] = 8'h01;
    card_bytes[17] = 8'hAA;
    exp_q.delete();
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'hAA);
    bus_if.res_ack = 1'b1;
    do_reset();
    wait_state(3'd7, ok);
    checks++; if (ok !== 1'b1) $display("FAIL cmd8_reach_done: got %b expected 1", ok); else passes++;
    checks++; if (obs_q.size() != exp_q.size()) $display("FAIL cmd8_strobes: got %0d expected %0d", obs_q.size(), exp_q.size()); else passes++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL cmd8_data[%0d]: got %02h expected %02h", i, obs_q[i], exp_q[i]);
      else passes++;
    end
    checks++; if (mosi_q.size() != 18) $display("FAIL cmd8_mosi_len: got %0d expected 18", mosi_q.size()); else passes++;
    for (int i = 0; i < 6 && (i + 7) < mosi_q.size(); i++) begin
      checks++;
      if (mosi_q[i + 7] !== exp_cmd[i]) $display("FAIL cmd8_byte[%0d]: got %02h expected %02h", i, mosi_q[i + 7], exp_cmd[i]);
      else passes++;
    end
  endtask
`endif

  // ------------------------------------------------------------ sequence + report
  initial begin
    bus_if.res_ack = 1'b1;
    load_card_all_ff();
    test_reset();
    test_init_cmd0();
    test_mid_reset();
    test_r1();
    test_timeout();
    test_backpressure();
`ifdef CARD_DRIVER_CMD8_EN
    test_cmd8();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
